// File: rtl/intersection_pkg.sv
// -----------------------------------------------------------------------------
// intersection_pkg
// Shared definitions for the intersection signal controller:
//   - lamp codes driven per phase onto outLight
//   - controller state encoding
//   - phase_width(): width of the phase index, never less than one bit
// No ports; imported by interval_timer and intersection_ctrl.
// -----------------------------------------------------------------------------
package intersection_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_GREEN  = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;
    localparam logic [1:0] LIGHT_DARK   = 2'b11;

    typedef enum logic [2:0] {
        sClear  = 3'd0,
        sGreen  = 3'd1,
        sYellow = 3'd2,
        sWalk   = 3'd3,
        sFlash  = 3'd4
    } state_t;

    // Index width for n phases; a two-phase controller still needs one bit.
    function automatic int phase_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
// Counts timebase ticks within the current controller interval.
//   clk   in   master clock
//   rstb  in   synchronous active-low reset, count -> 0
//   tick  in   one-cycle timebase enable, +1 per tick
//   clr   in   synchronous clear; wins over a coincident tick
//   count out  C_TW-bit tick count, saturates at all-ones
// -----------------------------------------------------------------------------
module interval_timer
    import intersection_pkg::*;
#(
    parameter int C_TW = 8
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            tick,
    input  logic            clr,
    output logic [C_TW-1:0] count
);

    localparam logic [C_TW-1:0] COUNT_MAX  = {C_TW{1'b1}};
    localparam logic [C_TW-1:0] COUNT_ZERO = {C_TW{1'b0}};
    localparam logic [C_TW-1:0] COUNT_ONE  = {{(C_TW-1){1'b0}}, 1'b1};

    logic [C_TW-1:0] count_r;

    // Tick counter with clear priority and saturation at the top value.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            count_r <= COUNT_ZERO;
        end else if (clr) begin
            count_r <= COUNT_ZERO;
        end else if (tick && (count_r != COUNT_MAX)) begin
            count_r <= count_r + COUNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/intersection_ctrl.sv
// -----------------------------------------------------------------------------
// intersection_ctrl
// Round-robin signal controller for C_PHASES conflicting vehicle phases with
// demand skipping, minimum-green gap-out, all-red clearance, an exclusive
// pedestrian walk interval and a night flashing-yellow mode.
//   clk           in   master clock
//   rstb          in   synchronous active-low reset
//   tick          in   one-cycle timebase enable (interval unit)
//   inMode        in   1 = pedestrian priority, 0 = vehicle priority
//   inFlash       in   night flash request, honoured only during all-red
//   inPedestrian  in   pedestrian button (latched until walk is served)
//   inTraffic     in   per-phase vehicle presence
//   outLight      out  per-phase lamp code, phase k on bits [2k+1:2k]
//   outWalk       out  walk lamp
//   outPhase      out  current or last served phase index
// All outputs are registers; lamps are decoded from the next state so they
// change on the same edge as the state register.
// -----------------------------------------------------------------------------
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int C_PHASES        = 2,
    parameter int C_TW            = 8,
    parameter int C_INT_GREEN     = 200,
    parameter int C_INT_MIN_GREEN = 40,
    parameter int C_INT_YELLOW    = 20,
    parameter int C_INT_CLEAR     = 5,
    parameter int C_INT_WALK      = 100
) (
    input  logic                                  clk,
    input  logic                                  rstb,
    input  logic                                  tick,
    input  logic                                  inMode,
    input  logic                                  inFlash,
    input  logic                                  inPedestrian,
    input  logic [C_PHASES-1:0]                   inTraffic,
    output logic [2*C_PHASES-1:0]                 outLight,
    output logic                                  outWalk,
    output logic [phase_width(C_PHASES)-1:0]      outPhase
);

    localparam int PW = phase_width(C_PHASES);

    localparam logic [C_TW-1:0] T_GREEN     = C_TW'(C_INT_GREEN);
    localparam logic [C_TW-1:0] T_MIN_GREEN = C_TW'(C_INT_MIN_GREEN);
    localparam logic [C_TW-1:0] T_YELLOW    = C_TW'(C_INT_YELLOW);
    localparam logic [C_TW-1:0] T_CLEAR     = C_TW'(C_INT_CLEAR);
    localparam logic [C_TW-1:0] T_WALK      = C_TW'(C_INT_WALK);
    localparam logic [PW-1:0]   LAST_PHASE  = PW'(C_PHASES - 1);

    // Parameter legality is settled at elaboration.
    if ((C_PHASES < 2) || (C_PHASES > 8)) begin : g_bad_phases
        $error("intersection_ctrl: C_PHASES must be in 2..8");
    end
    if ((C_INT_GREEN >= (1 << C_TW)) || (C_INT_MIN_GREEN >= (1 << C_TW)) ||
        (C_INT_YELLOW >= (1 << C_TW)) || (C_INT_CLEAR >= (1 << C_TW)) ||
        (C_INT_WALK >= (1 << C_TW))) begin : g_bad_interval
        $error("intersection_ctrl: an interval does not fit in C_TW bits");
    end
    if (C_INT_MIN_GREEN > C_INT_GREEN) begin : g_bad_min_green
        $error("intersection_ctrl: C_INT_MIN_GREEN exceeds C_INT_GREEN");
    end

    // First phase after cur (cyclically, cur itself last) that has demand;
    // with no demand anywhere the plain successor is served.
    function automatic logic [PW-1:0] next_phase(input logic [PW-1:0]       cur,
                                                 input logic [C_PHASES-1:0] traffic);
        logic [PW-1:0] result;
        logic          found;
        int            idx;
        result = (cur == LAST_PHASE) ? {PW{1'b0}} : (cur + {{(PW-1){1'b0}}, 1'b1});
        found  = 1'b0;
        for (int k = 1; k <= C_PHASES; k++) begin
            idx = (int'(cur) + k) % C_PHASES;
            if (!found && traffic[idx]) begin
                found  = 1'b1;
                result = PW'(idx);
            end else begin
                found  = found;
            end
        end
        return result;
    endfunction

    state_t                state_r;
    state_t                state_s;
    logic [PW-1:0]         phase_r;
    logic [PW-1:0]         phase_s;
    logic                  ped_r;
    logic                  ped_s;
    logic                  tog_r;
    logic                  tog_s;
    logic [2*C_PHASES-1:0] light_r;
    logic [2*C_PHASES-1:0] light_s;
    logic                  walk_r;
    logic                  walk_s;
    logic [C_TW-1:0]       timer_s;
    logic                  timer_clr_s;
    logic                  gap_out_s;
    logic                  ped_exit_s;
    logic [C_PHASES-1:0]   other_traffic_s;

    // Interval timer restarts whenever the controller changes state.
    interval_timer #(
        .C_TW (C_TW)
    ) u_timer (
        .clk   (clk),
        .rstb  (rstb),
        .tick  (tick),
        .clr   (timer_clr_s),
        .count (timer_s)
    );

    // Next state, next served phase and early-exit conditions.
    always_comb begin
        state_s         = state_r;
        phase_s         = phase_r;
        other_traffic_s = inTraffic & ~({{(C_PHASES-1){1'b0}}, 1'b1} << phase_r);
        gap_out_s       = !inTraffic[phase_r] && (other_traffic_s != {C_PHASES{1'b0}});
        ped_exit_s      = inMode && ped_r;
        case (state_r)
            sClear: begin
                if (inFlash) begin
                    state_s = sFlash;
                end else if (timer_s >= T_CLEAR) begin
                    if (ped_r) begin
                        state_s = sWalk;
                    end else begin
                        state_s = sGreen;
                        phase_s = next_phase(phase_r, inTraffic);
                    end
                end else begin
                    state_s = sClear;
                end
            end
            sGreen: begin
                if ((timer_s >= T_GREEN) ||
                    ((timer_s >= T_MIN_GREEN) && (ped_exit_s || gap_out_s))) begin
                    state_s = sYellow;
                end else begin
                    state_s = sGreen;
                end
            end
            sYellow: begin
                if (timer_s >= T_YELLOW) begin
                    state_s = sClear;
                end else begin
                    state_s = sYellow;
                end
            end
            sWalk: begin
                if (timer_s >= T_WALK) begin
                    state_s = sClear;
                end else begin
                    state_s = sWalk;
                end
            end
            sFlash: begin
                if (!inFlash) begin
                    state_s = sClear;
                end else begin
                    state_s = sFlash;
                end
            end
            default: begin
                state_s = sClear;
            end
        endcase
        timer_clr_s = (state_s != state_r);
    end

    // Pedestrian latch and flash toggle updates.
    always_comb begin
        ped_s = ped_r;
        tog_s = 1'b0;
        // Entering walk consumes the request; presses during walk are ignored.
        if ((state_s == sWalk) && (state_r != sWalk)) begin
            ped_s = 1'b0;
        end else if ((state_r != sWalk) && inPedestrian) begin
            ped_s = 1'b1;
        end else begin
            ped_s = ped_r;
        end
        if ((state_r == sFlash) && (state_s == sFlash)) begin
            tog_s = tick ? !tog_r : tog_r;
        end else begin
            tog_s = 1'b0;
        end
    end

    // Lamp decode from the next state so lamps track the state register.
    always_comb begin
        light_s = {(2*C_PHASES){1'b0}};
        walk_s  = (state_s == sWalk);
        for (int k = 0; k < C_PHASES; k++) begin
            case (state_s)
                sGreen: begin
                    light_s[2*k +: 2] = (PW'(k) == phase_s) ? LIGHT_GREEN : LIGHT_RED;
                end
                sYellow: begin
                    light_s[2*k +: 2] = (PW'(k) == phase_s) ? LIGHT_YELLOW : LIGHT_RED;
                end
                sFlash: begin
                    light_s[2*k +: 2] = tog_s ? LIGHT_YELLOW : LIGHT_DARK;
                end
                default: begin
                    light_s[2*k +: 2] = LIGHT_RED;
                end
            endcase
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_r <= sClear;
            phase_r <= LAST_PHASE;
            ped_r   <= 1'b0;
            tog_r   <= 1'b0;
            light_r <= {(2*C_PHASES){1'b0}};
            walk_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            ped_r   <= ped_s;
            tog_r   <= tog_s;
            light_r <= light_s;
            walk_r  <= walk_s;
        end
    end

    assign outLight = light_r;
    assign outWalk  = walk_r;
    assign outPhase = phase_r;

endmodule

// File: tb/tb_intersection_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intersection_ctrl
// Directed scenarios followed by randomized inputs. A behavioural model pushes
// every expected output change (with the cycle it must appear in) into a
// queue; a monitor pops an entry whenever the DUT outputs change.
// -----------------------------------------------------------------------------
module tb_intersection_ctrl;

    localparam int NP     = 3;
    localparam int GREEN  = 8;
    localparam int MIN_G  = 3;
    localparam int YELLOW = 2;
    localparam int CLEAR  = 1;
    localparam int WALK   = 4;

    localparam int M_CLEAR  = 0;
    localparam int M_GREEN  = 1;
    localparam int M_YELLOW = 2;
    localparam int M_WALK   = 3;
    localparam int M_FLASH  = 4;

    logic       clk;
    logic       rstb;
    logic       tick;
    logic       inMode;
    logic       inFlash;
    logic       inPedestrian;
    logic [2:0] inTraffic;
    logic [5:0] outLight;
    logic       outWalk;
    logic [1:0] outPhase;

    intersection_ctrl #(
        .C_PHASES        (NP),
        .C_TW            (8),
        .C_INT_GREEN     (GREEN),
        .C_INT_MIN_GREEN (MIN_G),
        .C_INT_YELLOW    (YELLOW),
        .C_INT_CLEAR     (CLEAR),
        .C_INT_WALK      (WALK)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .tick         (tick),
        .inMode       (inMode),
        .inFlash      (inFlash),
        .inPedestrian (inPedestrian),
        .inTraffic    (inTraffic),
        .outLight     (outLight),
        .outWalk      (outWalk),
        .outPhase     (outPhase)
    );

    typedef struct {
        int         cyc;
        logic [5:0] light;
        logic       walk;
        logic [1:0] phase;
    } ev_t;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  started  = 1'b0;

    // Behavioural model state: what the intersection is doing, in plain terms.
    int  m_mode    = M_CLEAR;
    int  m_phase   = NP - 1;
    int  m_elapsed = 0;
    bit  m_ped     = 1'b0;
    bit  m_tog     = 1'b0;
    ev_t m_prev    = '{cyc: 0, light: 6'b000000, walk: 1'b0, phase: 2'd2};

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle tick every 4 clocks.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    function automatic int pick_phase(input int cur, input logic [2:0] traffic);
        for (int k = 1; k <= NP; k++) begin
            if (traffic[(cur + k) % NP]) return (cur + k) % NP;
        end
        return (cur + 1) % NP;
    endfunction

    function automatic logic [5:0] lamps(input int mode, input int phase, input bit tog);
        logic [5:0] v;
        v = 6'b000000;
        for (int k = 0; k < NP; k++) begin
            if (mode == M_GREEN && k == phase)       v[2*k +: 2] = 2'b01;
            else if (mode == M_YELLOW && k == phase) v[2*k +: 2] = 2'b10;
            else if (mode == M_FLASH)                v[2*k +: 2] = tog ? 2'b10 : 2'b11;
            else                                     v[2*k +: 2] = 2'b00;
        end
        return v;
    endfunction

    // Reference model: advanced once per clock with the inputs seen at the edge.
    initial begin
        int  nm;
        int  np;
        bit  others;
        bit  leave;
        ev_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rstb) begin
                m_mode = M_CLEAR; m_phase = NP - 1; m_elapsed = 0;
                m_ped = 1'b0; m_tog = 1'b0;
            end else begin
                nm = m_mode;
                np = m_phase;
                case (m_mode)
                    M_CLEAR: begin
                        if (inFlash) nm = M_FLASH;
                        else if (m_elapsed >= CLEAR) begin
                            if (m_ped) nm = M_WALK;
                            else begin nm = M_GREEN; np = pick_phase(m_phase, inTraffic); end
                        end
                    end
                    M_GREEN: begin
                        others = 1'b0;
                        for (int k = 0; k < NP; k++) if (k != m_phase && inTraffic[k]) others = 1'b1;
                        leave = (m_elapsed >= GREEN) ||
                                (m_elapsed >= MIN_G && ((inMode && m_ped) ||
                                                        (!inTraffic[m_phase] && others)));
                        if (leave) nm = M_YELLOW;
                    end
                    M_YELLOW: if (m_elapsed >= YELLOW) nm = M_CLEAR;
                    M_WALK:   if (m_elapsed >= WALK) nm = M_CLEAR;
                    M_FLASH:  if (!inFlash) nm = M_CLEAR;
                    default:  nm = M_CLEAR;
                endcase
                if (m_mode != M_WALK) begin
                    if (nm == M_WALK) m_ped = 1'b0;
                    else if (inPedestrian) m_ped = 1'b1;
                end
                if (m_mode == M_FLASH && nm == M_FLASH) begin
                    if (tick) m_tog = !m_tog;
                end else begin
                    m_tog = 1'b0;
                end
                if (nm != m_mode) m_elapsed = 0;
                else if (tick && m_elapsed < 255) m_elapsed++;
                m_mode  = nm;
                m_phase = np;
            end
            e.cyc   = cyc;
            e.light = lamps(m_mode, m_phase, m_tog);
            e.walk  = (m_mode == M_WALK);
            e.phase = 2'(m_phase);
            if (e.light != m_prev.light || e.walk != m_prev.walk || e.phase != m_prev.phase) begin
                exp_q.push_back(e);
            end
            m_prev = e;
        end
    end

    // Monitor: every DUT output change must match the oldest expected change.
    initial begin
        logic [5:0] l_light;
        logic       l_walk;
        logic [1:0] l_phase;
        ev_t        e;
        int         lit;
        bit         flashy;
        wait (started);
        l_light = 6'b000000; l_walk = 1'b0; l_phase = 2'd2;
        forever begin
            @(negedge clk);
            if (outLight != l_light || outWalk != l_walk || outPhase != l_phase) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_light", int'(outLight), int'(e.light));
                    check("event_walk", int'(outWalk), int'(e.walk));
                    check("event_phase", int'(outPhase), int'(e.phase));
                end
                lit = 0;
                for (int k = 0; k < NP; k++) if (outLight[2*k +: 2] != 2'b00) lit++;
                flashy = (outLight == 6'b101010) || (outLight == 6'b111111);
                check("single_phase_lit", int'(flashy || lit <= 1), 1);
                l_light = outLight; l_walk = outWalk; l_phase = outPhase;
            end
        end
    end

    task automatic wait_light(input logic [1:0] code, input int bound, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            for (int k = 0; k < NP; k++) if (outLight[2*k +: 2] == code) seen = 1'b1;
        end
        check(name, int'(seen), 1);
    endtask

    task automatic wait_phase0_green(input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (outPhase == 2'd0 && outLight[1:0] == 2'b01) seen = 1'b1;
        end
        check("wait_phase0_green", int'(seen), 1);
    endtask

    task automatic wait_walk(input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (outWalk) seen = 1'b1;
        end
        check("wait_walk", int'(seen), 1);
    endtask

    task automatic press();
        inPedestrian = 1'b1;
        @(negedge clk);
        inPedestrian = 1'b0;
    endtask

    // Stimulus.
    initial begin
        rstb = 1'b0; inMode = 1'b0; inFlash = 1'b0; inPedestrian = 1'b0;
        inTraffic = 3'b000;
        repeat (3) @(negedge clk);
        check("reset_light", int'(outLight), 0);
        check("reset_walk", int'(outWalk), 0);
        check("reset_phase", int'(outPhase), NP - 1);
        started = 1'b1;
        @(negedge clk);
        rstb = 1'b1;

        // Full demand: plain round robin.
        inTraffic = 3'b111;
        repeat (200) @(negedge clk);

        // Only phase 1 has demand.
        inTraffic = 3'b010;
        repeat (150) @(negedge clk);

        // Gap-out of phase 0 towards phase 2.
        inTraffic = 3'b111;
        wait_phase0_green(300);
        repeat (4) @(negedge clk);
        inTraffic = 3'b100;
        repeat (150) @(negedge clk);

        // Pedestrian priority, plus a press ignored during walk.
        inMode = 1'b1;
        inTraffic = 3'b111;
        wait_light(2'b01, 300, "wait_green_ped");
        repeat (4) @(negedge clk);
        press();
        wait_walk(300);
        repeat (2) @(negedge clk);
        press();
        repeat (150) @(negedge clk);
        inMode = 1'b0;

        // Night flash requested mid-green.
        wait_light(2'b01, 300, "wait_green_flash");
        inFlash = 1'b1;
        repeat (150) @(negedge clk);
        inFlash = 1'b0;
        repeat (100) @(negedge clk);

        // Reset during yellow drops the pending pedestrian request.
        wait_light(2'b10, 300, "wait_yellow");
        press();
        rstb = 1'b0;
        @(negedge clk);
        check("midreset_light", int'(outLight), 0);
        check("midreset_walk", int'(outWalk), 0);
        rstb = 1'b1;
        repeat (100) @(negedge clk);

        // Randomized traffic, buttons, mode, flash and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) inTraffic = 3'($urandom_range(0, 7));
            inPedestrian = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 199) == 0) inMode = ~inMode;
            if ($urandom_range(0, 399) == 0) inFlash = ~inFlash;
            rstb = ($urandom_range(0, 999) != 0);
            @(negedge clk);
        end
        rstb = 1'b1; inPedestrian = 1'b0; inFlash = 1'b0;
        repeat (60) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
